// File: rtl/padctrl_sequencer_if.sv
// padctrl_sequencer_if: register-side targets in, live pad controls out.
interface padctrl_sequencer_if #(
    parameter int N_GROUPS = 9,
    parameter int N_GPIO   = 6,
    parameter int DWELL_W  = 8
);
    logic                  enable;
    logic [DWELL_W-1:0]    dwell;
    logic [2*N_GROUPS-1:0] tgt_drive;
    logic [N_GPIO-1:0]     tgt_pu;
    logic [N_GPIO-1:0]     tgt_pd;
    logic [2*N_GROUPS-1:0] drive;
    logic [N_GPIO-1:0]     pu;
    logic [N_GPIO-1:0]     pd;
    logic                  busy;
    modport master (output enable, dwell, tgt_drive, tgt_pu, tgt_pd, input drive, pu, pd, busy);
    modport slave  (input enable, dwell, tgt_drive, tgt_pu, tgt_pd, output drive, pu, pd, busy);
endinterface

// File: rtl/padctrl_sequencer.sv
// padctrl_sequencer: ramps live pad drive/pull controls toward their targets,
// one bit-field step at a time with a programmable dwell between steps.
module padctrl_sequencer #(
    parameter int         N_GROUPS    = 9,
    parameter int         N_GPIO      = 6,
    parameter int         DWELL_W     = 8,
    parameter logic [1:0] RESET_DRIVE = 2'b01
) (
    input logic                clk,
    input logic                rst_n,
    padctrl_sequencer_if.slave io_bus
);
    typedef enum logic {IDLE, DWELL} state_t;
    state_t                r_state, w_state_nxt;
    logic [DWELL_W-1:0]    r_cnt, w_cnt_nxt;
    logic [2*N_GROUPS-1:0] r_drive, w_drive_nxt;
    logic [N_GPIO-1:0]     r_pu, r_pd, w_pu_nxt, w_pd_nxt, w_pd_eff;
    logic                  w_mismatch, w_step, w_found;

    // pull-up wins when both pulls are requested
    assign w_pd_eff   = io_bus.tgt_pd & ~io_bus.tgt_pu;
    assign w_mismatch = (r_drive != io_bus.tgt_drive) || (r_pu != io_bus.tgt_pu) || (r_pd != w_pd_eff);
    assign w_step     = (r_state == IDLE) && io_bus.enable && w_mismatch;

    always_comb begin
        w_drive_nxt = r_drive;
        w_pu_nxt    = r_pu;
        w_pd_nxt    = r_pd;
        w_found     = 1'b0;
        for (int g = 0; g < N_GROUPS; g++) begin
            if (!w_found && r_drive[2*g +: 2] != io_bus.tgt_drive[2*g +: 2]) begin
                w_found = 1'b1;
                w_drive_nxt[2*g +: 2] = (io_bus.tgt_drive[2*g +: 2] > r_drive[2*g +: 2]) ?
                                        r_drive[2*g +: 2] + 2'd1 : r_drive[2*g +: 2] - 2'd1;
            end
        end
        // break-before-make: drop an unwanted pull before asserting the wanted one
        for (int i = 0; i < N_GPIO; i++) begin
            if (!w_found && (r_pu[i] != io_bus.tgt_pu[i] || r_pd[i] != w_pd_eff[i])) begin
                w_found = 1'b1;
                if (r_pu[i] && !io_bus.tgt_pu[i])
                    w_pu_nxt[i] = 1'b0;
                else if (r_pd[i] && !w_pd_eff[i])
                    w_pd_nxt[i] = 1'b0;
                else if (io_bus.tgt_pu[i])
                    w_pu_nxt[i] = 1'b1;
                else
                    w_pd_nxt[i] = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (r_state == DWELL) begin
            w_cnt_nxt   = r_cnt - DWELL_W'(1);
            w_state_nxt = (r_cnt == DWELL_W'(1)) ? IDLE : DWELL;
        end else if (w_step && io_bus.dwell != '0) begin
            w_state_nxt = DWELL;
            w_cnt_nxt   = io_bus.dwell;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_drive <= {N_GROUPS{RESET_DRIVE}};
            r_pu    <= '0;
            r_pd    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_step) begin
                r_drive <= w_drive_nxt;
                r_pu    <= w_pu_nxt;
                r_pd    <= w_pd_nxt;
            end
        end
    end

    assign io_bus.drive = r_drive;
    assign io_bus.pu    = r_pu;
    assign io_bus.pd    = r_pd;
    assign io_bus.busy  = rst_n && ((r_state != IDLE) || w_mismatch);
endmodule
